// File: rtl/eprom_fetch_arbiter.sv
// eprom_fetch_arbiter: shares the boot EPROM between the instruction-fetch
// unit and the data/loader port. It arbitrates round-robin, sequences
// chip-select and output-enable around a programmable access window, and
// returns the captured byte with a one-cycle acknowledge.
//
// Handshake: a requester raises req with a stable address and keeps req high
// until it sees its one-cycle ack. req must be low in the cycle after ack,
// otherwise that cycle is taken as a new request. The address is sampled only
// when the request is granted. A req dropped after the grant does not cancel
// the access: the transaction completes and ack still pulses.
module eprom_fetch_arbiter #(
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ack,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              _rom_cs,
  output logic              _rom_oe,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [1:0]        dbg_state
);

  localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Grant encoding: 1'b0 = instruction fetch, 1'b1 = data/loader.
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              winner_q, winner_d;
  logic              last_grant_q, last_grant_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              pick;

  // State register and datapath flops; reset deselects the EPROM at once.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rom_addr_q   <= '0;
      rd_data_q    <= '0;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rom_addr_q   <= rom_addr_d;
      rd_data_q    <= rd_data_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
    end
  end

  // Next-state logic: arbitration in IDLE, access window timing, capture and ack.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rom_addr_d   = rom_addr_q;
    rd_data_d    = rd_data_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    pick         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          // On a tie the requester not served last wins; otherwise the sole requester.
          pick         = (if_req && d_req) ? ~last_grant_q : d_req;
          winner_d     = pick;
          last_grant_d = pick;
          rom_addr_d   = pick ? d_addr : if_addr;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          rd_data_d = rom_data;
          if_ack_d  = ~winner_q;
          d_ack_d   = winner_q;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // EPROM strobes decode straight from the state register so reset releases them immediately.
  assign _rom_cs   = ~((state_q == ST_SETUP) || (state_q == ST_ACCESS));
  assign _rom_oe   = ~(state_q == ST_ACCESS);
  assign busy      = (state_q != ST_IDLE);
  assign rom_addr  = rom_addr_q;
  assign rd_data   = rd_data_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_eprom_fetch_arbiter.sv
// tb_eprom_fetch_arbiter: directed and randomized checks of the EPROM fetch
// arbiter against a transaction-level model of its grant/timing rules.
module tb_eprom_fetch_arbiter;

  localparam int W  = 3;
  localparam int AW = 20;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (WAIT_CYCLES = 3)
  logic          if_req, d_req, if_ack, d_ack, busy, rom_cs_n, rom_oe_n;
  logic [AW-1:0] if_addr, d_addr, rom_addr;
  logic [7:0]    rd_data, rom_data;
  logic [1:0]    dbg_state;

  // short-window instance (WAIT_CYCLES = 1)
  logic          if_req1, d_req1, if_ack1, d_ack1, busy1, rom_cs1_n, rom_oe1_n;
  logic [AW-1:0] if_addr1, d_addr1, rom_addr1;
  logic [7:0]    rd_data1, rom_data1;
  logic [1:0]    dbg_state1;

  // EPROM contents; 0x10 holds 0xA5, everything else a scrambled address.
  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    if (a == 20'h00010) return 8'hA5;
    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'h3C;
  endfunction

  // ECL EPROM: deselected bus reads as zero.
  assign rom_data  = rom_cs_n  ? 8'h00 : rom_byte(rom_addr);
  assign rom_data1 = rom_cs1_n ? 8'h00 : rom_byte(rom_addr1);

  eprom_fetch_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk(clk), ._reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack),
    .rd_data(rd_data), .busy(busy),
    ._rom_cs(rom_cs_n), ._rom_oe(rom_oe_n),
    .rom_addr(rom_addr), .rom_data(rom_data), .dbg_state(dbg_state)
  );

  eprom_fetch_arbiter #(.WAIT_CYCLES(1), .ADDR_W(AW)) dut1 (
    .clk(clk), ._reset(rst_n),
    .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1),
    .d_req(d_req1), .d_addr(d_addr1), .d_ack(d_ack1),
    .rd_data(rd_data1), .busy(busy1),
    ._rom_cs(rom_cs1_n), ._rom_oe(rom_oe1_n),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // One transaction in flight at most: granted in cycle g, it owns the
  // EPROM for g+1..g+W+1, acks in g+W+2, and the arbiter is free at g+W+3.
  int            free_at  = 1 << 30;
  int            ack_cyc  = -100;
  logic          ack_who  = 1'b0;   // 0 = fetch, 1 = data
  logic          last_g   = 1'b1;
  logic [AW-1:0] exp_addr = '0;
  logic [7:0]    exp_rd   = '0;
  logic [7:0]    exp_q[$];

  // observations for the directed steps
  int if_acks, d_acks, oe_low, if_at, d_at;
  int if1_acks, d1_acks, oe1_low, if1_at;
  logic [7:0] rd1_at_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ack_cyc  = -100;
    exp_q.delete();
    exp_addr = '0;
    exp_rd   = '0;
    last_g   = 1'b1;
    free_at  = 1 << 30;
  endtask

  task automatic check_outputs();
    logic in_cs, in_oe, in_busy, at_ack;
    in_cs   = (cyc >= ack_cyc - W - 1) && (cyc <= ack_cyc - 1);
    in_oe   = (cyc >= ack_cyc - W) && (cyc <= ack_cyc - 1);
    in_busy = (cyc >= ack_cyc - W - 1) && (cyc <= ack_cyc);
    at_ack  = (cyc == ack_cyc);
    if (at_ack && exp_q.size() > 0) exp_rd = exp_q.pop_front();
    check("if_ack",   32'(if_ack),   32'(at_ack && !ack_who));
    check("d_ack",    32'(d_ack),    32'(at_ack && ack_who));
    check("rom_cs_n", 32'(rom_cs_n), 32'(!in_cs));
    check("rom_oe_n", 32'(rom_oe_n), 32'(!in_oe));
    check("busy",     32'(busy),     32'(in_busy));
    check("dbg_idle", 32'(dbg_state == 2'd0), 32'(!in_busy));
    check("rom_addr", 32'(rom_addr), 32'(exp_addr));
    check("rd_data",  32'(rd_data),  32'(exp_rd));
    if (if_ack === 1'b1) begin if_acks++; if_at = cyc; end
    if (d_ack === 1'b1) begin d_acks++; d_at = cyc; end
    if (rom_oe_n === 1'b0) oe_low++;
    if (if_ack1 === 1'b1) begin if1_acks++; if1_at = cyc; rd1_at_ack = rd_data1; end
    if (d_ack1 === 1'b1) d1_acks++;
    if (rom_oe1_n === 1'b0) oe1_low++;
  endtask

  // Model consumes this cycle's inputs, then the clock advances and outputs are checked.
  task automatic cycle_end();
    logic w;
    if (rst_n && cyc >= free_at && (if_req || d_req)) begin
      w        = (if_req && d_req) ? ~last_g : d_req;
      last_g   = w;
      ack_who  = w;
      exp_addr = w ? d_addr : if_addr;
      exp_q.push_back(rom_byte(exp_addr));
      ack_cyc  = cyc + W + 2;
      free_at  = cyc + W + 3;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic clear_obs();
    if_acks = 0; d_acks = 0; oe_low = 0; if_at = -1; d_at = -1;
    if1_acks = 0; d1_acks = 0; oe1_low = 0; if1_at = -1; rd1_at_ack = '0;
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  logic       who[4];
  int         at[4];
  logic [7:0] dat[4];
  int         n_seen, t0;
  logic       cool_i, cool_d;

  initial begin
    rst_n = 1'b0;
    if_req = 1'b1; d_req = 1'b1; if_addr = 20'h00055; d_addr = 20'h000AA;
    if_req1 = 1'b0; d_req1 = 1'b0; if_addr1 = '0; d_addr1 = '0;
    clear_obs();

    // Reset held with both requests high: everything at reset values.
    #1;
    check_outputs();
    repeat (3) cycle_end();
    check("reset_no_ack", 32'(if_acks + d_acks), 32'd0);

    if_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b1;
    free_at = cyc;
    repeat (2) cycle_end();

    // Contention right after reset: fetch wins the first tie, then alternate.
    if_addr = 20'h00001; d_addr = 20'h00002;
    if_req = 1'b1; d_req = 1'b1;
    n_seen = 0;
    for (int k = 0; k < 60 && n_seen < 4; k++) begin
      cycle_end();
      if (if_ack === 1'b1 || d_ack === 1'b1) begin
        who[n_seen] = d_ack;
        at[n_seen]  = cyc;
        dat[n_seen] = rd_data;
        n_seen++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("cont_ack_count", 32'(n_seen), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("cont_order", 32'(who[k]), 32'(k % 2));
      check("cont_data",  32'(dat[k]), 32'(rom_byte((k % 2) != 0 ? 20'h00002 : 20'h00001)));
      if (k > 0) check("cont_spacing", 32'(at[k] - at[k-1]), 32'd6);
    end
    repeat (3) cycle_end();

    // Single fetch of 0x10.
    clear_obs();
    if_addr = 20'h00010; if_req = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      cycle_end();
      if (if_ack === 1'b1) if_req = 1'b0;
    end
    if_req = 1'b0;
    check("single_ack_count", 32'(if_acks), 32'd1);
    check("single_latency",   32'(if_at - t0), 32'd5);
    check("single_oe_cycles", 32'(oe_low), 32'd3);
    check("single_no_d_ack",  32'(d_acks), 32'd0);
    check("single_rd_data",   32'(rd_data), 32'hA5);

    // Address change during the access window is ignored.
    clear_obs();
    if_addr = 20'h00004; if_req = 1'b1;
    cycle_end();
    cycle_end();
    if_addr = 20'h00008;
    for (int k = 0; k < 10; k++) begin
      cycle_end();
      if (if_ack === 1'b1) if_req = 1'b0;
    end
    if_req = 1'b0;
    check("addrchg_ack_count", 32'(if_acks), 32'd1);
    check("addrchg_rom_addr",  32'(rom_addr), 32'h4);
    check("addrchg_rd_data",   32'(rd_data), 32'(rom_byte(20'h00004)));

    // Reset in the second ACCESS cycle aborts the access.
    clear_obs();
    d_addr = 20'h00123; d_req = 1'b1;
    repeat (3) cycle_end();
    check("midrst_oe_active", 32'(rom_oe_n), 32'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_cs_n",  32'(rom_cs_n), 32'd1);
    check("midrst_oe_n",  32'(rom_oe_n), 32'd1);
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_d_ack", 32'(d_ack), 32'd0);
    repeat (2) cycle_end();
    check("midrst_no_ack", 32'(if_acks + d_acks), 32'd0);
    rst_n = 1'b1;
    free_at = cyc;
    t0 = cyc;
    for (int k = 0; k < 12; k++) begin
      cycle_end();
      if (d_ack === 1'b1) d_req = 1'b0;
    end
    d_req = 1'b0;
    check("midrst_after_ack",  32'(d_acks), 32'd1);
    check("midrst_after_lat",  32'(d_at - t0), 32'd5);
    check("midrst_after_data", 32'(rd_data), 32'(rom_byte(20'h00123)));

    // Randomized traffic from both requesters, protocol-compliant.
    cool_i = 1'b0; cool_d = 1'b0;
    for (int k = 0; k < 400; k++) begin
      cycle_end();
      if (cyc == ack_cyc && !ack_who) begin
        if_req = 1'b0; cool_i = 1'b1;
      end else if (cool_i) begin
        cool_i = 1'b0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = AW'($urandom_range(0, 32'hFFFFF));
      end else if (if_req && $urandom_range(0, 7) == 0) begin
        if_addr = AW'($urandom_range(0, 32'hFFFFF));
      end
      if (cyc == ack_cyc && ack_who) begin
        d_req = 1'b0; cool_d = 1'b1;
      end else if (cool_d) begin
        cool_d = 1'b0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = AW'($urandom_range(0, 32'hFFFFF));
      end else if (d_req && $urandom_range(0, 7) == 0) begin
        d_addr = AW'($urandom_range(0, 32'hFFFFF));
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (10) cycle_end();

    // WAIT_CYCLES = 1 instance.
    clear_obs();
    if_addr1 = 20'h00077; if_req1 = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      cycle_end();
      if (if_ack1 === 1'b1) if_req1 = 1'b0;
    end
    if_req1 = 1'b0;
    check("w1_ack_count", 32'(if1_acks), 32'd1);
    check("w1_latency",   32'(if1_at - t0), 32'd3);
    check("w1_oe_cycles", 32'(oe1_low), 32'd1);
    check("w1_rd_data",   32'(rd1_at_ack), 32'(rom_byte(20'h00077)));
    check("w1_no_d_ack",  32'(d1_acks), 32'd0);
    check("w1_idle",      32'(busy1 || (dbg_state1 != 2'd0)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eprom_fetch_arbiter.md
# eprom_fetch_arbiter

Sequences every access to the main boot EPROM and shares it between two requesters: the instruction-fetch unit and the data/loader port. It arbitrates round-robin, drives the EPROM chip-select, output-enable and address with a programmable access window, captures the byte and returns it with a one-cycle acknowledge. It sits between the core's fetch logic and the main EPROM. The EPROM is ECL and has no hi-Z state, so its data bus reads as zeroes whenever it is deselected.

## Interface
- WAIT_CYCLES, 3: number of cycles `_rom_oe` is held low before `rom_data` is sampled. Must be ≥1. The counter is $clog2(WAIT_CYCLES+1) bits.
- ADDR_W, 20: EPROM address width.

- clk  in  1  system clock; all state changes on the rising edge.
- _reset  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction-fetch request.
- if_addr  in  ADDR_W  instruction-fetch byte address.
- if_ack  out  1  one-cycle pulse; `rd_data` is valid for the instruction-fetch requester.
- d_req  in  1  data/loader request.
- d_addr  in  ADDR_W  data/loader byte address.
- d_ack  out  1  one-cycle pulse; `rd_data` is valid for the data/loader requester.
- rd_data  out  8  captured EPROM byte (registered).
- busy  out  1  high whenever the FSM is not in IDLE.
- _rom_cs  out  1  EPROM chip select, active low.
- _rom_oe  out  1  EPROM output enable, active low.
- rom_addr  out  ADDR_W  EPROM address (registered).
- rom_data  in  8  EPROM data bus.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester not granted last. `last_grant` resets to "data", so instruction fetch wins the first tie.
  - On a grant: latch the winner's address into `rom_addr`, record the winner, update `last_grant`, go to SETUP.
- **SETUP** (1 cycle): `_rom_cs`=0, `_rom_oe`=1. Load the wait counter with WAIT_CYCLES−1. Go to ACCESS.
- **ACCESS** (WAIT_CYCLES cycles): `_rom_cs`=0, `_rom_oe`=0.
  - Decrement the counter each cycle.
  - On the edge where the counter is 0: register `rom_data` into `rd_data` and go to DONE.
- **DONE** (1 cycle): `_rom_cs`=1, `_rom_oe`=1. Assert the granted requester's ack (registered). Go to IDLE.
- Address handling: the address is sampled only at grant. Later changes to `if_addr`/`d_addr` do not affect the transaction in flight.
- Request protocol:
  - The requester holds req high until it sees ack.
  - req must be low in the cycle after ack. A req still high in that IDLE cycle is a new request.
  - If req is dropped mid-transaction, the transaction still completes and ack still pulses.
- Hold behaviour:
  - `rd_data` holds the last captured byte until the next capture.
  - `rom_addr` holds its last value through DONE and IDLE.
- Only one of `if_ack`/`d_ack` may be high in any cycle. Neither may be high outside DONE.

## Timing
- Reset values (asynchronous, effective immediately on `_reset` low):
  - state = IDLE
  - `_rom_cs` = 1, `_rom_oe` = 1
  - `rom_addr` = 0, `rd_data` = 0
  - `if_ack` = 0, `d_ack` = 0, `busy` = 0
  - `last_grant` = data
- Reset mid-transaction aborts it: no ack is produced, and the EPROM is deselected at once.
- Latency: request seen in IDLE at cycle 0 → SETUP at cycle 1 → ACCESS at cycles 2..WAIT_CYCLES+1 → ack in cycle WAIT_CYCLES+2. With the default, ack arrives 5 cycles after the request.
- Throughput: one transaction per WAIT_CYCLES+3 cycles. The mandatory IDLE cycle between transactions is the ECL bus-settle gap. Under continuous contention from both requesters, grants alternate.
- `_rom_oe` is never low while `_rom_cs` is high. The address is stable for the full SETUP+ACCESS window.
- Simultaneous requests in the IDLE cycle right after DONE: resolved by `last_grant`. The requester just served loses.

## Test plan
- **Reset:** hold `_reset`=0 with both requests high → all outputs at reset values, `busy`=0, no ack.
- **Single fetch:** `if_req`=1, `if_addr`=0x00010, ROM[0x10]=0xA5, default WAIT_CYCLES → `if_ack` high for exactly one cycle, 5 cycles after the request; `rd_data`=0xA5; `_rom_oe` low for exactly 3 cycles; `d_ack` never asserted.
- **Contention:** both requests held continuously, addresses 0x1 and 0x2 → grant order if, d, if, d. Each ack carries the correct byte. Each ack is 6 cycles after the previous one.
- **Address change mid-access:** change `if_addr` from 0x4 to 0x8 during ACCESS → `rom_addr` stays 0x4 and `rd_data` = ROM[0x4].
- **Reset mid-transaction:** pull `_reset` low in the second ACCESS cycle → `_rom_cs`/`_rom_oe` go to 1 immediately; no ack. After reset is released with `d_req` held, a transaction completes normally.
- **WAIT_CYCLES=1:** `_rom_oe` low for 1 cycle; ack 3 cycles after the request; the captured byte is correct.
